stereo_fade_mixer: RTL and testbench

- Sits between the music player's sample output and the AC97 codec playback inputs.
- Replaces the hard AND-masking of the sample by the stereo state with per-channel gain ramps, so left/right enable changes and mutes fade instead of clicking.
- Latches samples on new_sample and emits one left/right PCM pair per codec frame request (new_frame).
- Tracks frames that arrive with no fresh sample (underruns) for debug display.

---
 rtl/stereo_fade_mixer.sv | 121 ++++++++++++
 tb/tb_stereo_fade_mixer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_fade_mixer.sv
// Stereo fade mixer: gain-ramped left/right PCM for the codec.
// Ports: clk, reset_n, sample/new_sample in, new_frame request,
//   aural_state/mute set the gain targets; pcm_left/pcm_right
//   with out_valid pulse, ramp_active, underrun_count out.
module stereo_fade_mixer #(
  parameter int GAIN_STEP = 1,
  parameter int UNITY     = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sample,
  input  logic        new_sample,
  input  logic        new_frame,
  input  logic [1:0]  aural_state,
  input  logic        mute,
  output logic [15:0] pcm_left,
  output logic [15:0] pcm_right,
  output logic        out_valid,
  output logic        ramp_active,
  output logic [7:0]  underrun_count
);

  localparam logic [8:0] UNITY_G = 9'(UNITY);
  localparam logic [9:0] STEP_W  = 10'(GAIN_STEP);

  logic [15:0] sample_hold_q, sample_hold_d;
  logic        fresh_q, fresh_d;
  logic [8:0]  gain_l_q, gain_l_d;
  logic [8:0]  gain_r_q, gain_r_d;
  logic [15:0] pcm_left_q, pcm_left_d;
  logic [15:0] pcm_right_q, pcm_right_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  underrun_q, underrun_d;

  logic [8:0]  target_l, target_r;
  logic signed [25:0] prod_l, prod_r;
  logic        unused_bits;

  // Move one step toward the target, clamped to [0, UNITY].
  function automatic logic [8:0] step_gain(
    input logic [8:0] g,
    input logic [8:0] t
  );
    logic [9:0] up;
    logic [9:0] gw;
    gw = {1'b0, g};
    up = gw + STEP_W;
    if (g < t)
      step_gain = (up > {1'b0, UNITY_G}) ? UNITY_G : up[8:0];
    else if (g > t)
      step_gain = (gw < STEP_W) ? 9'd0 : 9'(gw - STEP_W);
    else
      step_gain = g;
  endfunction

  always_comb begin
    target_l = (aural_state[0] & ~mute) ? UNITY_G : 9'd0;
    target_r = (aural_state[1] & ~mute) ? UNITY_G : 9'd0;
  end

  // Gain is unsigned, so zero-extend before the signed multiply.
  always_comb begin
    prod_l = $signed(sample_hold_q) * $signed({1'b0, gain_l_q});
    prod_r = $signed(sample_hold_q) * $signed({1'b0, gain_r_q});
  end

  assign unused_bits = ^{prod_l[25:24], prod_l[7:0],
                         prod_r[25:24], prod_r[7:0]};

  always_comb begin
    sample_hold_d = sample_hold_q;
    gain_l_d      = gain_l_q;
    gain_r_d      = gain_r_q;
    pcm_left_d    = pcm_left_q;
    pcm_right_d   = pcm_right_q;
    underrun_d    = underrun_q;
    out_valid_d   = new_frame;
    fresh_d       = new_sample | (fresh_q & ~new_frame);
    if (new_sample)
      sample_hold_d = sample;
    // The frame uses the held sample and pre-step gain.
    if (new_frame) begin
      pcm_left_d  = prod_l[23:8];
      pcm_right_d = prod_r[23:8];
      gain_l_d    = step_gain(gain_l_q, target_l);
      gain_r_d    = step_gain(gain_r_q, target_r);
      if (!fresh_q && underrun_q != 8'hFF)
        underrun_d = underrun_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_hold_q <= '0;
      fresh_q       <= 1'b0;
      gain_l_q      <= '0;
      gain_r_q      <= '0;
      pcm_left_q    <= '0;
      pcm_right_q   <= '0;
      out_valid_q   <= 1'b0;
      underrun_q    <= '0;
    end else begin
      sample_hold_q <= sample_hold_d;
      fresh_q       <= fresh_d;
      gain_l_q      <= gain_l_d;
      gain_r_q      <= gain_r_d;
      pcm_left_q    <= pcm_left_d;
      pcm_right_q   <= pcm_right_d;
      out_valid_q   <= out_valid_d;
      underrun_q    <= underrun_d;
    end
  end

  assign pcm_left       = pcm_left_q;
  assign pcm_right      = pcm_right_q;
  assign out_valid      = out_valid_q;
  assign underrun_count = underrun_q;
  assign ramp_active    = (gain_l_q != target_l) |
                          (gain_r_q != target_r);

endmodule

// File: tb/tb_stereo_fade_mixer.sv
// Bench for stereo_fade_mixer: reference model feeds a
// scoreboard queue, drained on every out_valid pulse.
module tb_stereo_fade_mixer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] sample;
  logic        new_sample;
  logic        new_frame;
  logic [1:0]  aural_state;
  logic        mute;
  logic [15:0] pcm_left;
  logic [15:0] pcm_right;
  logic        out_valid;
  logic        ramp_active;
  logic [7:0]  underrun_count;

  stereo_fade_mixer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample         (sample),
    .new_sample     (new_sample),
    .new_frame      (new_frame),
    .aural_state    (aural_state),
    .mute           (mute),
    .pcm_left       (pcm_left),
    .pcm_right      (pcm_right),
    .out_valid      (out_valid),
    .ramp_active    (ramp_active),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int frames   = 0;
  int pulses   = 0;

  logic [31:0] exp_q[$];

  int          mg_l, mg_r;
  logic [15:0] mhold;
  bit          mfresh;
  int          mund;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] scale(input logic [15:0] s,
                                        input int g);
    int p;
    p = int'($signed(s)) * g;
    p = p >>> 8;
    return p[15:0];
  endfunction

  function automatic int next_gain(input int g, input int t);
    if (t > g) return (g + 1 > 256) ? 256 : g + 1;
    if (t < g) return (g - 1 < 0) ? 0 : g - 1;
    return g;
  endfunction

  task automatic model_reset();
    mg_l = 0; mg_r = 0; mhold = 0; mfresh = 0; mund = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      logic [31:0] e;
      pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_left", int'(pcm_left), int'(e[31:16]));
        chk("sb_right", int'(pcm_right), int'(e[15:0]));
      end
    end
  end

  task automatic load(input logic [15:0] s);
    @(negedge clk);
    new_sample = 1'b1;
    sample = s;
    mhold = s;
    mfresh = 1'b1;
    @(negedge clk);
    new_sample = 1'b0;
  endtask

  task automatic frame(input bit ns, input logic [15:0] s);
    int tl, tr;
    @(negedge clk);
    new_frame = 1'b1;
    new_sample = ns;
    sample = s;
    tl = (aural_state[0] && !mute) ? 256 : 0;
    tr = (aural_state[1] && !mute) ? 256 : 0;
    exp_q.push_back({scale(mhold, mg_l), scale(mhold, mg_r)});
    frames++;
    if (!mfresh && mund < 255) mund++;
    mg_l = next_gain(mg_l, tl);
    mg_r = next_gain(mg_r, tr);
    mfresh = ns;
    if (ns) mhold = s;
    @(negedge clk);
    new_frame = 1'b0;
    new_sample = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    sample = '0;
    new_sample = 1'b0;
    new_frame = 1'b0;
    aural_state = 2'b11;
    mute = 1'b0;
    model_reset();
    #23;
    chk("rst_left", int'(pcm_left), 0);
    chk("rst_right", int'(pcm_right), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_underrun", int'(underrun_count), 0);
    chk("rst_ramp", int'(ramp_active), 1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 1; i <= 257; i++) begin
      load(16'h4000);
      frame(1'b0, 16'h0);
      if (i == 1) chk("f1_left", int'(pcm_left), 16'h0000);
      if (i == 2) chk("f2_left", int'(pcm_left), 16'h0040);
      if (i == 255) chk("ramp_f255", int'(ramp_active), 1);
      if (i == 256) chk("ramp_f256", int'(ramp_active), 0);
    end
    chk("f257_left", int'(pcm_left), 16'h4000);
    chk("f257_right", int'(pcm_right), 16'h4000);
    chk("ramp_underrun", int'(underrun_count), 0);

    aural_state = 2'b10;
    for (int i = 1; i <= 257; i++) begin
      load(16'h4000);
      frame(1'b0, 16'h0);
      if (i == 2) chk("dec_f2_left", int'(pcm_left), 16'h3FC0);
    end
    chk("dec_left", int'(pcm_left), 16'h0000);
    chk("dec_right", int'(pcm_right), 16'h4000);

    aural_state = 2'b11;
    for (int i = 0; i < 128; i++) begin
      load(16'h0100);
      frame(1'b0, 16'h0);
    end
    load(16'h8000);
    frame(1'b0, 16'h0);
    chk("g128_neg_full", int'(pcm_left), 16'hC000);
    chk("unity_neg_full", int'(pcm_right), 16'h8000);
    aural_state = 2'b10;
    load(16'hFFFF);
    frame(1'b0, 16'h0);
    chk("g129_minus1", int'(pcm_left), 16'hFFFF);
    load(16'h7FFF);
    frame(1'b0, 16'h0);
    chk("g128_pos_full", int'(pcm_left), 16'h3FFF);

    for (int i = 0; i < 300; i++)
      frame(1'b0, 16'h0);
    chk("underrun_sat", int'(underrun_count), 255);

    do_reset();
    chk("rst2_underrun", int'(underrun_count), 0);
    aural_state = 2'b11;
    for (int i = 0; i < 256; i++) begin
      load(16'h1000);
      frame(1'b0, 16'h0);
    end
    load(16'h1000);
    frame(1'b1, 16'h1234);
    chk("same_cyc_out", int'(pcm_left), 16'h1000);
    chk("same_cyc_und", int'(underrun_count), 0);
    frame(1'b0, 16'h0);
    chk("next_out", int'(pcm_left), 16'h1234);
    chk("next_und", int'(underrun_count), 0);
    frame(1'b0, 16'h0);
    chk("third_und", int'(underrun_count), 1);

    do_reset();
    for (int i = 0; i < 100; i++) begin
      load(16'h4000);
      frame(1'b0, 16'h0);
    end
    mute = 1'b1;
    for (int i = 0; i < 40; i++) begin
      load(16'h4000);
      frame(1'b0, 16'h0);
    end
    chk("mute_down_left", int'(pcm_left), 16'h0F40);
    mute = 1'b0;
    load(16'h4000);
    frame(1'b0, 16'h0);
    chk("unmute_g60", int'(pcm_left), 16'h0F00);
    for (int i = 0; i < 195; i++) begin
      load(16'h4000);
      frame(1'b0, 16'h0);
    end
    chk("unmute_settled", int'(ramp_active), 0);
    load(16'h4000);
    frame(1'b0, 16'h0);
    chk("unmute_unity", int'(pcm_left), 16'h4000);

    aural_state = 2'b01;
    for (int i = 0; i < 10; i++) begin
      load(16'h4000);
      frame(1'b0, 16'h0);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_left", int'(pcm_left), 0);
    chk("async_right", int'(pcm_right), 0);
    chk("async_valid", int'(out_valid), 0);
    chk("async_und", int'(underrun_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", int'(out_valid), 0);
    end
    load(16'h4000);
    frame(1'b0, 16'h0);
    chk("post_rst_pulse", int'(out_valid), 1);
    chk("post_rst_left", int'(pcm_left), 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("pulse_count", pulses, frames);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
